regfile_rename: RTL

- Parametrised architectural register file with rename tags for the out-of-order core.
- Sits between the dispatcher (source reads, destination locks) and the ROB (in-order commit writes).
- Generalises the two-port regfile:
  - configurable width, register count, tag width and number of read ports;
  - adds ROB flush (mispredict recovery), a registered pending-register count, and defined priority for every same-cycle collision.

---
 rtl/regfile_rename.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags and pending bits.
// Commits write data in order; renames lock registers until the matching tag commits.
module regfile_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int TAG_W = 4,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush_i,
    input  logic                 cm_en_i,
    input  logic [TAG_W-1:0]     cm_tag_i,
    input  logic [AW-1:0]        cm_addr_i,
    input  logic [XLEN-1:0]      cm_data_i,
    input  logic                 rn_en_i,
    input  logic [AW-1:0]        rn_addr_i,
    input  logic [TAG_W-1:0]     rn_tag_i,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD-1:0]       rd_valid_o,
    output logic [NRD-1:0]       rd_pend_o,
    output logic [NRD*TAG_W-1:0] rd_tag_o,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [AW:0]          busy_cnt_o
);

    logic [XLEN-1:0]  r_data [NREG];
    logic [TAG_W-1:0] r_tag  [NREG];
    logic [NREG-1:0]  r_pend;
    logic [AW:0]      r_busy_cnt;

    logic             w_cm_wr;
    logic             w_cm_hit;
    logic             w_rn_wr;
    logic [NREG-1:0]  w_pend_next;
    logic [AW:0]      w_busy_next;

    assign w_cm_wr  = cm_en_i && (cm_addr_i != '0);
    assign w_cm_hit = w_cm_wr && r_pend[cm_addr_i] && (r_tag[cm_addr_i] == cm_tag_i);
    assign w_rn_wr  = rn_en_i && (rn_addr_i != '0) && !flush_i;

    // Commit clears first so a same-cycle rename of the same register wins.
    always_comb begin
        w_pend_next = r_pend;
        if (w_cm_hit)
            w_pend_next[cm_addr_i] = 1'b0;
        if (flush_i)
            w_pend_next = '0;
        else if (w_rn_wr)
            w_pend_next[rn_addr_i] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_comb begin
        w_busy_next = '0;
        for (int i = 0; i < NREG; i++)
            w_busy_next = w_busy_next + (AW+1)'(w_pend_next[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_pend     <= '0;
            r_busy_cnt <= '0;
        end else if (rdy) begin
            if (w_cm_wr)
                r_data[cm_addr_i] <= cm_data_i;
            if (w_rn_wr)
                r_tag[rn_addr_i] <= rn_tag_i;
            r_pend     <= w_pend_next;
            r_busy_cnt <= w_busy_next;
        end
    end

    assign busy_cnt_o = r_busy_cnt;

    // Read ports see pre-edge state only; a matching commit is forwarded.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]    w_addr;
            logic             w_fwd;
            logic             w_valid;
            logic             w_pend;
            logic [TAG_W-1:0] w_tag;
            logic [XLEN-1:0]  w_data;

            assign w_addr = rd_addr_i[gi*AW +: AW];
            assign w_fwd  = cm_en_i && (cm_addr_i == w_addr) && r_pend[w_addr]
                            && (r_tag[w_addr] == cm_tag_i);

            always_comb begin
                w_valid = 1'b0;
                w_pend  = 1'b0;
                w_tag   = '0;
                w_data  = '0;
                if (!rst && rd_en_i[gi]) begin
                    w_valid = 1'b1;
                    if (w_addr == '0) begin
                        w_data = '0;
                    end else if (w_fwd) begin
                        w_data = cm_data_i;
                    end else if (r_pend[w_addr]) begin
                        w_pend = 1'b1;
                        w_tag  = r_tag[w_addr];
                    end else begin
                        w_data = r_data[w_addr];
                    end
                end
            end

            assign rd_valid_o[gi]              = w_valid;
            assign rd_pend_o[gi]               = w_pend;
            assign rd_tag_o[gi*TAG_W +: TAG_W] = w_tag;
            assign rd_data_o[gi*XLEN +: XLEN]  = w_data;
        end
    endgenerate

endmodule
